// File: rtl/riscv_master_port_pkg.sv
// AHB encodings and the master-port state type shared by the interconnect port logic.
package riscv_mpsoc_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DIRECT     = 3'd1,
        ST_WAIT_GRANT = 3'd2,
        ST_ERR1       = 3'd3,
        ST_ERR2       = 3'd4
    } mst_port_state_t;

    function automatic logic is_active_trans(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/riscv_master_port_decoder.sv
// Address-to-slave decode: lowest-indexed matching slave wins, miss when none match.
module riscv_master_port_decoder #(
    parameter int SLAVES = 8,
    parameter int PLEN   = 64,
    parameter int IDXW   = 3
) (
    input  logic [PLEN-1:0]   addr,
    input  logic [PLEN-1:0]   mask [SLAVES],
    input  logic [PLEN-1:0]   base [SLAVES],
    output logic [SLAVES-1:0] hit_onehot,
    output logic [IDXW-1:0]   hit_idx,
    output logic              miss
);

    localparam logic [SLAVES-1:0] SEL_LSB = SLAVES'(1'b1);

    // Scan from the top so the lowest matching index is the last one written
    always_comb begin
        hit_idx    = '0;
        miss       = 1'b1;
        hit_onehot = '0;
        for (int s = SLAVES - 1; s >= 0; s--) begin
            if ((addr & mask[s]) == (base[s] & mask[s])) begin
                hit_idx = IDXW'(s);
                miss    = 1'b0;
            end else begin
                hit_idx = hit_idx;
            end
        end
        if (miss) begin
            hit_onehot = '0;
        end else begin
            hit_onehot = SEL_LSB << hit_idx;
        end
    end

endmodule

// File: rtl/riscv_master_port.sv
// Per-master AHB port: decodes to a slave port, bypasses or buffers the request
// depending on grant, and returns the data-phase response to the master.
module riscv_master_port
    import riscv_mpsoc_pkg::*;
#(
    parameter int         PLEN            = 64,
    parameter int         XLEN            = 64,
    parameter int         SLAVES          = 8,
    parameter logic [2:0] MASTER_PRIORITY = 3'd0
) (
    input  logic              HCLK,
    input  logic              HRESET,

    input  logic              mstHSEL,
    input  logic [PLEN-1:0]   mstHADDR,
    input  logic [XLEN-1:0]   mstHWDATA,
    input  logic              mstHWRITE,
    input  logic [2:0]        mstHSIZE,
    input  logic [2:0]        mstHBURST,
    input  logic [3:0]        mstHPROT,
    input  logic [1:0]        mstHTRANS,
    input  logic              mstHMASTLOCK,
    input  logic              mstHREADY,
    output logic [XLEN-1:0]   mstHRDATA,
    output logic              mstHREADYOUT,
    output logic              mstHRESP,

    input  logic [PLEN-1:0]   slvHADDR_MASK [SLAVES],
    input  logic [PLEN-1:0]   slvHADDR_BASE [SLAVES],
    output logic [2:0]        slvpriority   [SLAVES],
    output logic [SLAVES-1:0] slvHSEL,
    output logic [PLEN-1:0]   slvHADDR,
    output logic [XLEN-1:0]   slvHWDATA,
    output logic              slvHWRITE,
    output logic [2:0]        slvHSIZE,
    output logic [2:0]        slvHBURST,
    output logic [3:0]        slvHPROT,
    output logic [1:0]        slvHTRANS,
    output logic              slvHMASTLOCK,
    output logic              slvHREADY,
    input  logic [XLEN-1:0]   slvHRDATA     [SLAVES],
    input  logic [SLAVES-1:0] slvHREADYOUT,
    input  logic [SLAVES-1:0] slvHRESP,
    output logic [SLAVES-1:0] can_switch,
    input  logic [SLAVES-1:0] granted
);

    localparam int                IDXW    = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam logic [SLAVES-1:0] SEL_LSB = SLAVES'(1'b1);

    mst_port_state_t   state_r;
    logic [PLEN-1:0]   buf_addr_r;
    logic              buf_write_r;
    logic [2:0]        buf_size_r;
    logic [2:0]        buf_burst_r;
    logic [3:0]        buf_prot_r;
    logic [1:0]        buf_trans_r;
    logic              buf_lock_r;
    logic [IDXW-1:0]   buf_idx_r;
    logic [IDXW-1:0]   dp_idx_r;

    logic [SLAVES-1:0] dec_onehot_s;
    logic [IDXW-1:0]   dec_idx_s;
    logic              dec_miss_s;
    logic              acc_s;
    logic              waiting_s;
    logic              bypass_s;
    logic              hold_s;
    logic [SLAVES-1:0] target_s;

    riscv_master_port_decoder #(
        .SLAVES (SLAVES),
        .PLEN   (PLEN),
        .IDXW   (IDXW)
    ) u_decoder (
        .addr       (mstHADDR),
        .mask       (slvHADDR_MASK),
        .base       (slvHADDR_BASE),
        .hit_onehot (dec_onehot_s),
        .hit_idx    (dec_idx_s),
        .miss       (dec_miss_s)
    );

    assign acc_s     = mstHSEL & mstHREADY & is_active_trans(mstHTRANS);
    assign waiting_s = (state_r == ST_WAIT_GRANT);
    // The buffer is only occupied in WAIT_GRANT, so outside it the request may bypass
    assign bypass_s  = ~waiting_s & mstHSEL & ~dec_miss_s & granted[dec_idx_s];
    assign slvHWDATA = mstHWDATA;

    // Transaction FSM, data-phase slave index and ungranted-request buffer
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r     <= ST_IDLE;
            dp_idx_r    <= '0;
            buf_addr_r  <= '0;
            buf_write_r <= 1'b0;
            buf_size_r  <= 3'd0;
            buf_burst_r <= HBURST_SINGLE;
            buf_prot_r  <= 4'd0;
            buf_trans_r <= HTRANS_IDLE;
            buf_lock_r  <= 1'b0;
            buf_idx_r   <= '0;
        end else begin
            case (state_r)
                ST_WAIT_GRANT: begin
                    if (granted[buf_idx_r] && slvHREADYOUT[buf_idx_r]) begin
                        state_r  <= ST_DIRECT;
                        dp_idx_r <= buf_idx_r;
                    end
                end
                ST_ERR1: state_r <= ST_ERR2;
                ST_IDLE, ST_DIRECT, ST_ERR2: begin
                    if (acc_s) begin
                        if (dec_miss_s) begin
                            state_r <= ST_ERR1;
                        end else if (granted[dec_idx_s]) begin
                            state_r  <= ST_DIRECT;
                            dp_idx_r <= dec_idx_s;
                        end else begin
                            state_r     <= ST_WAIT_GRANT;
                            buf_addr_r  <= mstHADDR;
                            buf_write_r <= mstHWRITE;
                            buf_size_r  <= mstHSIZE;
                            buf_burst_r <= mstHBURST;
                            buf_prot_r  <= mstHPROT;
                            buf_trans_r <= mstHTRANS;
                            buf_lock_r  <= mstHMASTLOCK;
                            buf_idx_r   <= dec_idx_s;
                        end
                    end else if (mstHREADY || (state_r == ST_ERR2)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Response returned to the master for the current data phase
    always_comb begin
        mstHRDATA    = '0;
        mstHREADYOUT = 1'b1;
        mstHRESP     = HRESP_OKAY;
        case (state_r)
            ST_DIRECT: begin
                mstHRDATA    = slvHRDATA[dp_idx_r];
                mstHREADYOUT = slvHREADYOUT[dp_idx_r];
                mstHRESP     = slvHRESP[dp_idx_r];
            end
            ST_WAIT_GRANT: mstHREADYOUT = 1'b0;
            ST_ERR1: begin
                mstHREADYOUT = 1'b0;
                mstHRESP     = HRESP_ERROR;
            end
            ST_ERR2:  mstHRESP = HRESP_ERROR;
            ST_IDLE:  mstHRESP = HRESP_OKAY;
            default:  mstHRESP = HRESP_OKAY;
        endcase
    end

    // Request bundle toward the slave ports: buffered request wins, else bypass
    always_comb begin
        slvHADDR     = mstHADDR;
        slvHWRITE    = mstHWRITE;
        slvHSIZE     = mstHSIZE;
        slvHBURST    = mstHBURST;
        slvHPROT     = mstHPROT;
        slvHMASTLOCK = mstHMASTLOCK;
        slvHTRANS    = HTRANS_IDLE;
        slvHSEL      = '0;
        slvHREADY    = mstHREADY;
        if (waiting_s) begin
            slvHADDR     = buf_addr_r;
            slvHWRITE    = buf_write_r;
            slvHSIZE     = buf_size_r;
            slvHBURST    = buf_burst_r;
            slvHPROT     = buf_prot_r;
            slvHMASTLOCK = buf_lock_r;
            // A burst continuation that lost arbitration restarts as a fresh transfer
            slvHTRANS    = (buf_trans_r == HTRANS_SEQ) ? HTRANS_NONSEQ : buf_trans_r;
            slvHSEL      = SEL_LSB << buf_idx_r;
            slvHREADY    = 1'b1;
        end else if (bypass_s) begin
            slvHTRANS = mstHTRANS;
            slvHSEL   = dec_onehot_s;
        end else begin
            slvHSEL = '0;
        end
    end

    // Re-arbitration hint: block the slave this master is locked/bursting/waiting on
    always_comb begin
        hold_s   = mstHMASTLOCK |
                   (mstHSEL & (mstHBURST != HBURST_SINGLE) & (mstHTRANS != HTRANS_IDLE));
        target_s = '0;
        if (waiting_s) begin
            hold_s   = 1'b1;
            target_s = SEL_LSB << buf_idx_r;
        end else if (mstHSEL && !dec_miss_s) begin
            target_s = dec_onehot_s;
        end else if (state_r == ST_DIRECT) begin
            target_s = SEL_LSB << dp_idx_r;
        end else begin
            target_s = '0;
        end
        can_switch = hold_s ? ~target_s : '1;
    end

    // Static priority presented to every slave port
    always_comb begin
        for (int s = 0; s < SLAVES; s++) begin
            slvpriority[s] = MASTER_PRIORITY;
        end
    end

endmodule

// File: tb/tb_riscv_master_port.sv
// Self-checking bench for riscv_master_port: decode table, directed corner sequences
// and randomized single transfers checked against a transaction-level model.
module tb_riscv_master_port;
    import riscv_mpsoc_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        mstHSEL;
    logic [63:0] mstHADDR;
    logic [63:0] mstHWDATA;
    logic        mstHWRITE;
    logic [2:0]  mstHSIZE;
    logic [2:0]  mstHBURST;
    logic [3:0]  mstHPROT;
    logic [1:0]  mstHTRANS;
    logic        mstHMASTLOCK;
    logic        mstHREADY;
    logic [63:0] mstHRDATA;
    logic        mstHREADYOUT;
    logic        mstHRESP;
    logic [63:0] slvHADDR_MASK [8];
    logic [63:0] slvHADDR_BASE [8];
    logic [2:0]  slvpriority [8];
    logic [7:0]  slvHSEL;
    logic [63:0] slvHADDR;
    logic [63:0] slvHWDATA;
    logic        slvHWRITE;
    logic [2:0]  slvHSIZE;
    logic [2:0]  slvHBURST;
    logic [3:0]  slvHPROT;
    logic [1:0]  slvHTRANS;
    logic        slvHMASTLOCK;
    logic        slvHREADY;
    logic [63:0] slvHRDATA [8];
    logic [7:0]  slvHREADYOUT;
    logic [7:0]  slvHRESP;
    logic [7:0]  can_switch;
    logic [7:0]  granted;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  trans;
        logic        hsel;
        logic        lock;
        logic [2:0]  burst;
        logic [7:0]  gnt;
        logic [7:0]  exp_sel;
        logic [7:0]  exp_cs;
    } vec_t;
    vec_t vecs [10];

    always #5 HCLK = ~HCLK;
    assign mstHREADY = mstHREADYOUT;

    riscv_master_port dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE),
        .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY), .mstHRDATA(mstHRDATA),
        .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
        .slvHADDR_MASK(slvHADDR_MASK), .slvHADDR_BASE(slvHADDR_BASE), .slvpriority(slvpriority),
        .slvHSEL(slvHSEL), .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA), .slvHWRITE(slvHWRITE),
        .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST), .slvHPROT(slvHPROT), .slvHTRANS(slvHTRANS),
        .slvHMASTLOCK(slvHMASTLOCK), .slvHREADY(slvHREADY), .slvHRDATA(slvHRDATA),
        .slvHREADYOUT(slvHREADYOUT), .slvHRESP(slvHRESP), .can_switch(can_switch),
        .granted(granted)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mst_idle();
        mstHSEL      = 1'b0;
        mstHTRANS    = HTRANS_IDLE;
        mstHBURST    = HBURST_SINGLE;
        mstHMASTLOCK = 1'b0;
        mstHWRITE    = 1'b0;
    endtask

    task automatic mst_req(input logic [63:0] a, input logic [1:0] t, input logic wr);
        mstHSEL   = 1'b1;
        mstHADDR  = a;
        mstHTRANS = t;
        mstHWRITE = wr;
    endtask

    // Reference decode: lowest-indexed slave whose masked base matches, -1 on miss
    function automatic int model_decode(input logic [63:0] a);
        for (int s = 0; s < 8; s++) begin
            if ((a & slvHADDR_MASK[s]) == (slvHADDR_BASE[s] & slvHADDR_MASK[s])) return s;
        end
        return -1;
    endfunction

    // One isolated transfer from IDLE; grant for a hit arrives gdelay cycles after acceptance
    task automatic run_txn(input logic [63:0] a, input logic wr, input logic [1:0] t, input int gdelay);
        int         idx;
        int         low_cnt;
        logic [7:0] oh;
        logic [7:0] oth;
        idx = model_decode(a);
        oh  = (idx >= 0) ? (8'd1 << idx) : 8'd0;
        oth = 8'($urandom);
        slvHREADYOUT = 8'hFF;
        granted = (gdelay == 0) ? (oth | oh) : (oth & ~oh);
        mst_req(a, t, wr);
        #1;
        chk("txn_addr_sel", 64'(slvHSEL), 64'((gdelay == 0) ? oh : 8'd0));
        chk("txn_addr_ready", 64'(mstHREADYOUT), 64'd1);
        tick();
        mst_idle();
        if (idx < 0) begin
            #1;
            chk("txn_err1", 64'({mstHRESP, mstHREADYOUT}), 64'(2'b10));
            tick();
            chk("txn_err2", 64'({mstHRESP, mstHREADYOUT}), 64'(2'b11));
            tick();
            chk("txn_err_done", 64'({mstHRESP, mstHREADYOUT}), 64'(2'b01));
        end else begin
            low_cnt = 0;
            for (int c = 1; c <= 20; c++) begin
                if (c == gdelay) granted = granted | oh;
                #1;
                if (mstHREADYOUT) break;
                low_cnt++;
                chk("txn_wait_sel", 64'(slvHSEL), 64'(oh));
                chk("txn_wait_trans", 64'(slvHTRANS), 64'(HTRANS_NONSEQ));
                chk("txn_wait_addr", slvHADDR, a);
                @(posedge HCLK);
                #1;
            end
            chk("txn_wait_cycles", 64'(low_cnt), 64'(gdelay));
            chk("txn_rdata", mstHRDATA, slvHRDATA[idx]);
            chk("txn_resp", 64'(mstHRESP), 64'd0);
            tick();
            chk("txn_idle_ready", 64'(mstHREADYOUT), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] wd;
        logic [63:0] ra;
        int          r;
        HRESET = 1'b1;
        mstHADDR = 64'd0;
        mstHWDATA = 64'd0;
        mstHSIZE = 3'd3;
        mstHPROT = 4'd3;
        mst_idle();
        for (int s = 0; s < 8; s++) begin
            slvHADDR_MASK[s] = 64'hF000;
            slvHADDR_BASE[s] = 64'(s) << 12;
            slvHRDATA[s]     = {$urandom, $urandom};
        end
        slvHADDR_BASE[0] = 64'h8000;
        slvHADDR_BASE[6] = 64'h3800;
        slvHADDR_MASK[6] = 64'hF800;
        slvHREADYOUT = 8'hFF;
        slvHRESP     = 8'h00;
        granted      = 8'h00;
        repeat (3) tick();

        // Reset values
        chk("rst_ready", 64'(mstHREADYOUT), 64'd1);
        chk("rst_resp", 64'(mstHRESP), 64'd0);
        chk("rst_sel", 64'(slvHSEL), 64'd0);
        chk("rst_trans", 64'(slvHTRANS), 64'(HTRANS_IDLE));
        chk("rst_cs", 64'(can_switch), 64'hFF);
        chk("rst_rdata", mstHRDATA, 64'd0);
        chk("prio", 64'(slvpriority[5]), 64'd0);
        HRESET = 1'b0;
        tick();

        // Combinational decode / bypass / can_switch table, state IDLE throughout
        vecs[0] = '{64'h2010,      HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 8'hFF, 8'h04, 8'hFF};
        vecs[1] = '{64'h8004,      HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 8'hFF, 8'h01, 8'hFF};
        vecs[2] = '{64'h38F0,      HTRANS_SEQ,    1'b1, 1'b0, HBURST_SINGLE, 8'hFF, 8'h08, 8'hFF};
        vecs[3] = '{64'h7FFC,      HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 8'hFF, 8'h80, 8'hFF};
        vecs[4] = '{64'hFFFF_0000, HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{64'h5000,      HTRANS_NONSEQ, 1'b0, 1'b0, HBURST_SINGLE, 8'hFF, 8'h00, 8'hFF};
        vecs[6] = '{64'h4ABC,      HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 8'hEF, 8'h00, 8'hFF};
        vecs[7] = '{64'h2010,      HTRANS_NONSEQ, 1'b1, 1'b1, HBURST_SINGLE, 8'hFF, 8'h04, 8'hFB};
        vecs[8] = '{64'h1000,      HTRANS_SEQ,    1'b1, 1'b0, 3'b001,        8'hFF, 8'h02, 8'hFD};
        vecs[9] = '{64'h1_6000,    HTRANS_NONSEQ, 1'b1, 1'b0, HBURST_SINGLE, 8'hFF, 8'h00, 8'hFF};
        for (int i = 0; i < 10; i++) begin
            mst_req(vecs[i].addr, vecs[i].trans, 1'b0);
            mstHSEL      = vecs[i].hsel;
            mstHMASTLOCK = vecs[i].lock;
            mstHBURST    = vecs[i].burst;
            granted      = vecs[i].gnt;
            #1;
            chk("tbl_sel", 64'(slvHSEL), 64'(vecs[i].exp_sel));
            chk("tbl_cs", 64'(can_switch), 64'(vecs[i].exp_cs));
            if (vecs[i].exp_sel != 8'h00) chk("tbl_trans", 64'(slvHTRANS), 64'(vecs[i].trans));
            mst_idle();
            tick();
        end

        // Granted single write to slave 2
        wd = {$urandom, $urandom};
        granted = 8'h04;
        mst_req(64'h2010, HTRANS_NONSEQ, 1'b1);
        #1;
        chk("wr_sel", 64'(slvHSEL), 64'h04);
        chk("wr_write", 64'(slvHWRITE), 64'd1);
        chk("wr_addr", slvHADDR, 64'h2010);
        chk("wr_fields", 64'({slvHSIZE, slvHPROT, slvHBURST, slvHMASTLOCK, slvHREADY}),
            64'({3'd3, 4'd3, HBURST_SINGLE, 1'b0, 1'b1}));
        tick();
        mst_idle();
        mstHWDATA = wd;
        #1;
        chk("wr_wdata", slvHWDATA, wd);
        chk("wr_ready", 64'(mstHREADYOUT), 64'd1);
        chk("wr_resp", 64'(mstHRESP), 64'd0);
        tick();

        // Ungranted read to slave 1, grant three cycles later; then a decode miss
        run_txn(64'h1040, 1'b0, HTRANS_NONSEQ, 3);
        run_txn(64'hFFFF_0000, 1'b0, HTRANS_NONSEQ, 0);

        // Locked INCR4 burst to slave 0
        granted = 8'hFF;
        mstHMASTLOCK = 1'b1;
        mstHBURST    = 3'b011;
        for (int b = 0; b < 4; b++) begin
            mst_req(64'h8000 + 64'(b * 8), (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0);
            #1;
            chk("burst_cs", 64'(can_switch), 64'hFE);
            tick();
        end
        mst_idle();
        #1;
        chk("burst_cs_after", 64'(can_switch), 64'hFF);
        tick();

        // Reset while waiting for a grant drops the transfer
        granted = 8'h00;
        mst_req(64'h1040, HTRANS_NONSEQ, 1'b0);
        tick();
        mst_idle();
        #1;
        chk("rstw_waiting", 64'(mstHREADYOUT), 64'd0);
        HRESET = 1'b1;
        tick();
        chk("rstw_sel", 64'(slvHSEL), 64'd0);
        chk("rstw_ready", 64'(mstHREADYOUT), 64'd1);
        chk("rstw_cs", 64'(can_switch), 64'hFF);
        chk("rstw_trans", 64'(slvHTRANS), 64'(HTRANS_IDLE));
        HRESET  = 1'b0;
        granted = 8'hFF;
        tick();
        chk("rstw_dropped", 64'({slvHSEL, mstHREADYOUT}), 64'({8'h00, 1'b1}));

        // Back-to-back granted transfers to slave 3 then slave 5
        mst_req(64'h3000, HTRANS_NONSEQ, 1'b0);
        #1;
        chk("b2b_sel3", 64'(slvHSEL), 64'h08);
        tick();
        mst_req(64'h5000, HTRANS_NONSEQ, 1'b0);
        slvHREADYOUT = 8'hF7;
        #1;
        chk("b2b_sel5", 64'(slvHSEL), 64'h20);
        chk("b2b_stall3", 64'(mstHREADYOUT), 64'd0);
        tick();
        slvHREADYOUT = 8'hFF;
        #1;
        chk("b2b_ready3", 64'(mstHREADYOUT), 64'd1);
        chk("b2b_rdata3", mstHRDATA, slvHRDATA[3]);
        tick();
        mst_idle();
        #1;
        chk("b2b_rdata5", mstHRDATA, slvHRDATA[5]);
        tick();

        // Randomized isolated transfers against the transaction model
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 9));
            ra = {$urandom, $urandom};
            if (r < 8) ra[15:12] = slvHADDR_BASE[r][15:12];
            else ra[15:12] = (r == 8) ? 4'h9 : 4'h0;
            run_txn(ra, 1'($urandom), ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                    int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_master_port.md
Name: riscv_master_port

Overview:
- Upstream neighbour of the per-slave arbitration port. One instance exists per AHB master.
- It decodes the master's address to one of SLAVES slave ports and drives that port's per-master request bundle (HSEL, address and control, priority).
- It holds the transaction in a local buffer while the slave port has not granted this master. It returns HRDATA/HREADYOUT/HRESP to the master.
- It generates the can_switch indication that each slave port uses to decide when it may re-arbitrate.

Parameters:
- PLEN, 64, address width.
- XLEN, 64, data width.
- SLAVES, 8, number of slave ports driven.
- MASTER_PRIORITY, 3'd0, static priority presented on every slvpriority output.

Ports:
- HCLK  in  1  clock; all state updates on its rising edge.
- HRESET  in  1  reset; synchronous, active-high.
- mstHSEL/mstHADDR/mstHWDATA/mstHWRITE/mstHSIZE/mstHBURST/mstHPROT/mstHTRANS/mstHMASTLOCK  in  1/PLEN/XLEN/1/3/3/4/2/1  AHB master request.
- mstHREADY  in  1  master-bus HREADY.
- mstHRDATA  out  XLEN  read data to master.
- mstHREADYOUT  out  1  ready to master.
- mstHRESP  out  1  response to master.
- slvHADDR_MASK  in  [SLAVES][PLEN]  decode mask per slave.
- slvHADDR_BASE  in  [SLAVES][PLEN]  decode base per slave.
- slvpriority  out  [SLAVES][3]  priority presented to each slave port.
- slvHSEL  out  [SLAVES]  one-hot request to slave ports.
- slvHADDR/slvHWDATA/slvHWRITE/slvHSIZE/slvHBURST/slvHPROT/slvHTRANS/slvHMASTLOCK  out  shared  request bundle, broadcast to all slave ports.
- slvHREADY  out  1  master-side HREADY toward the slave ports.
- slvHRDATA  in  [SLAVES][XLEN]  read data from each slave port.
- slvHREADYOUT  in  [SLAVES]  ready from each slave port.
- slvHRESP  in  [SLAVES]  response from each slave port.
- can_switch  out  [SLAVES]  slave port may re-arbitrate away from this master.
- granted  in  [SLAVES]  this master's bit of each slave port's granted_master.

Behaviour:
- Decode: a hit on slave s means (HADDR & MASK[s]) == (BASE[s] & MASK[s]). The lowest index wins; no hit means a decode error.
- Transfer acceptance: a transfer is accepted when mstHSEL & mstHREADY & HTRANS ∈ {NONSEQ, SEQ}.
- States:
  - IDLE: no outstanding data phase.
  - DIRECT: data phase in progress on a granted slave.
  - WAIT_GRANT: buffered request waiting for grant.
  - ERR1, ERR2: two-cycle error response.
- Bypass: if the decoded slave has granted = 1 and the buffer is empty, the address phase passes combinationally to the slv* outputs, with slvHSEL one-hot on that slave. Zero added latency.
- Buffering: if the decoded slave is not granted, all address-phase fields and the slave index are registered. mstHREADYOUT = 0 until grant. State goes to WAIT_GRANT.
- WAIT_GRANT: slv* outputs are driven from the buffer.
  - If the buffered HTRANS is SEQ, it is re-issued as NONSEQ.
  - On granted[idx] & slvHREADYOUT[idx], the address phase completes and state goes to DIRECT.
- DIRECT: mstHRDATA, mstHREADYOUT and mstHRESP are muxed from the data-phase slave index, which is registered at address acceptance.
  - Pipelined back-to-back transfers to the same slave stay in DIRECT.
  - A transfer to a different slave takes the bypass/buffer decision above.
- Write data: slvHWDATA = mstHWDATA, passed through unregistered. The slave port applies its own delayed select.
- Decode miss: no slvHSEL is raised.
  - ERR1: mstHRESP = 1, mstHREADYOUT = 0.
  - ERR2: mstHRESP = 1, mstHREADYOUT = 1.
  - Then IDLE.
  - An IDLE/BUSY transfer with a decode miss gives an OKAY response and no error.
- can_switch[s] = 0 while any of these holds for this master on slave s:
  - a locked transfer is in progress (mstHMASTLOCK in the current or buffered request);
  - a burst is in progress (HBURST ≠ SINGLE and the next HTRANS is SEQ or BUSY);
  - state is WAIT_GRANT.
  Otherwise can_switch[s] = 1.
- Reset values: state IDLE, buffer invalid, slvHSEL = 0, slvHTRANS = IDLE, mstHREADYOUT = 1, mstHRESP = 0, can_switch = all ones, mstHRDATA = 0.
- Reset mid-transfer: HRESET takes priority on the next edge. All state and outputs return to their reset values, and the outstanding transfer is dropped.
- Simultaneous events: grant arriving in the same cycle the request is decoded uses the bypass path and does not load the buffer. Error during WAIT_GRANT cannot occur, because decode is resolved before buffering.

Decomposition:
- Shared package riscv_mpsoc_pkg holds:
  - HTRANS constants HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HBURST_SINGLE;
  - HRESP_OKAY/ERROR;
  - a state typedef mst_port_state_t.
- Sub-module riscv_master_port_decoder: combinational address-to-one-hot decode plus miss flag, parameterised by SLAVES and PLEN.

Test Plan:
- Granted single write to slave 2 (BASE 0x2000, MASK 0xF000, HADDR 0x2010) → slvHSEL = 8'b0000_0100 in the same cycle; no wait states added; mstHRESP = 0.
- Ungranted read to slave 1 with grant asserted 3 cycles later → mstHREADYOUT low for 3 cycles; slvHTRANS = NONSEQ from the buffer; mstHRDATA = slvHRDATA[1] on completion.
- HADDR 0xFFFF_0000 with no decode hit, NONSEQ → cycle 1 HRESP = 1/HREADYOUT = 0, cycle 2 HRESP = 1/HREADYOUT = 1, then IDLE.
- INCR4 burst with HMASTLOCK = 1 to slave 0 → can_switch[0] = 0 for all 4 beats and 1 the cycle after the last beat.
- HRESET asserted during WAIT_GRANT → next cycle state IDLE, slvHSEL = 0, mstHREADYOUT = 1, can_switch = 8'hFF.
- Back-to-back transfers to slave 3 then slave 5, both granted → slvHSEL switches 0x08 → 0x20 on consecutive cycles; the data phase of the first transfer uses slvHREADYOUT[3].
